// File: rtl/router_alloc_pkg.sv
// Shared types, port indices and the cyclic priority pick used by the output allocators.
package router_alloc_pkg;

    localparam int unsigned LOCAL      = 0;
    localparam int unsigned NORTH      = 1;
    localparam int unsigned SOUTH      = 2;
    localparam int unsigned EAST       = 3;
    localparam int unsigned WEST       = 4;
    localparam int unsigned NUM_PORTS  = WEST + 1;
    localparam int unsigned PORT_IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned CAND_W     = PORT_IDX_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] idx;
        logic [NUM_PORTS-1:0]  onehot;
    } rr_pick_t;

    // First set bit of elig[n-1:0] searched cyclically upward from ptr (ptr < n).
    function automatic rr_pick_t rr_pick(input logic [NUM_PORTS-1:0]  elig,
                                         input logic [PORT_IDX_W-1:0] ptr,
                                         input int unsigned           n);
        rr_pick_t          pick;
        logic [CAND_W-1:0] cand;
        pick = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = CAND_W'(ptr) + CAND_W'(k);
            if (cand >= CAND_W'(n)) begin
                cand = cand - CAND_W'(n);
            end
            if (!pick.valid && (k < n) && elig[cand[PORT_IDX_W-1:0]]) begin
                pick.valid                          = 1'b1;
                pick.idx                            = cand[PORT_IDX_W-1:0];
                pick.onehot[cand[PORT_IDX_W-1:0]]   = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; the pointer register is owned by the caller.
module rr_arbiter
    import router_alloc_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = NUM_PORTS,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] elig,
    input  logic [IDX_WIDTH-1:0]  ptr,
    output logic [NUM_INPUTS-1:0] gnt_c,
    output logic [IDX_WIDTH-1:0]  idx_c,
    output logic                  valid_c
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(NUM_PORTS'(elig), PORT_IDX_W'(ptr), NUM_INPUTS);
        gnt_c   = NUM_INPUTS'(pick.onehot);
        idx_c   = IDX_WIDTH'(pick.idx);
        valid_c = pick.valid;
    end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin packet lock, credit gating and crossbar select.
module output_port_allocator
    import router_alloc_pkg::*;
#(
    parameter int unsigned NUM_INPUTS        = 5,
    parameter int unsigned FLIT_BUFFER_DEPTH = 2,
    parameter int unsigned IDX_WIDTH         = $clog2(NUM_INPUTS),
    parameter int unsigned CRED_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] req_tail,
    input  logic [NUM_INPUTS-1:0] turn_disable,
    input  logic                  credit_in,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [IDX_WIDTH-1:0]  sel,
    output logic                  fire,
    output logic                  fire_tail,
    output logic                  locked,
    output logic [CRED_WIDTH-1:0] credits,
    output logic                  credit_err
);

    localparam logic [CRED_WIDTH-1:0] CRED_FULL = CRED_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_WIDTH-1:0]  IDX_LAST  = IDX_WIDTH'(NUM_INPUTS - 1);
    localparam logic [IDX_WIDTH-1:0]  IDX_FIRST = IDX_WIDTH'(LOCAL);

    alloc_state_e          state_q, state_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0]  owner_q, owner_d;
    logic [CRED_WIDTH-1:0] credits_q, credits_d;
    logic                  credit_err_q, credit_err_d;

    logic [NUM_INPUTS-1:0] elig;
    logic [NUM_INPUTS-1:0] arb_gnt;
    logic [IDX_WIDTH-1:0]  arb_idx;
    logic                  arb_valid;
    logic                  has_credit;
    logic [IDX_WIDTH-1:0]  win_idx;

    assign elig       = req & ~turn_disable;
    assign has_credit = (credits_q != '0);

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_rr_arbiter (
        .elig    (elig),
        .ptr     (rr_ptr_q),
        .gnt_c   (arb_gnt),
        .idx_c   (arb_idx),
        .valid_c (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDX_FIRST;
            owner_q      <= IDX_FIRST;
            credits_q    <= CRED_FULL;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Grant selection, lock tracking and credit accounting.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        grant        = '0;
        win_idx      = owner_q;
        fire         = 1'b0;
        fire_tail    = 1'b0;

        case (state_q)
            IDLE: begin
                if (has_credit && arb_valid) begin
                    grant   = arb_gnt;
                    win_idx = arb_idx;
                end
            end
            LOCKED: begin
                // Owner keeps the output; turn_disable only matters at packet start.
                if (has_credit && req[owner_q]) begin
                    grant[owner_q] = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset must silence the combinational grant path immediately.
        if (!rst_n) begin
            grant = '0;
        end

        fire = |grant;
        sel  = fire ? win_idx : owner_q;

        if (fire) begin
            owner_d   = win_idx;
            fire_tail = req_tail[win_idx];
            if (req_tail[win_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = (win_idx == IDX_LAST) ? IDX_FIRST : win_idx + IDX_WIDTH'(1);
            end else begin
                state_d = LOCKED;
            end
        end

        if (fire && !credit_in) begin
            credits_d = credits_q - CRED_WIDTH'(1);
        end else if (!fire && credit_in) begin
            if (credits_q == CRED_FULL) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CRED_WIDTH'(1);
            end
        end
    end

    assign locked     = (state_q == LOCKED);
    assign credits    = credits_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator against a packet-level reference model.
module tb_output_port_allocator;
    import router_alloc_pkg::*;

    localparam int N     = 5;
    localparam int DEPTH = 2;
    localparam logic [13:0] RESET_VEC = {5'b0, 1'b0, 1'b0, 3'b0, 1'b0, 2'd2, 1'b0};

    logic       clk, rst_n;
    logic [4:0] req, req_tail, turn_disable;
    logic       credit_in;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       fire, fire_tail, locked;
    logic [1:0] credits;
    logic       credit_err;
    logic [13:0] dut_vec;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit m_locked;
    int m_owner, m_ptr, m_cred, m_sel;
    bit m_err;

    output_port_allocator #(
        .NUM_INPUTS        (5),
        .FLIT_BUFFER_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_tail     (req_tail),
        .turn_disable (turn_disable),
        .credit_in    (credit_in),
        .grant        (grant),
        .sel          (sel),
        .fire         (fire),
        .fire_tail    (fire_tail),
        .locked       (locked),
        .credits      (credits),
        .credit_err   (credit_err)
    );

    assign dut_vec = {grant, fire, fire_tail, sel, locked, credits, credit_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic m_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_err = 0; m_sel = 0;
    endtask

    // Which input transfers this cycle, or -1.
    function automatic int m_winner();
        if (m_cred == 0) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i] && !turn_disable[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [13:0] m_vec(input int w);
        logic [4:0] g;
        logic [2:0] s;
        logic       ft;
        g  = '0;
        s  = 3'(m_sel);
        ft = 1'b0;
        if (w >= 0) begin
            g[w] = 1'b1;
            s    = 3'(w);
            ft   = req_tail[w];
        end
        return {g, (w >= 0), ft, s, m_locked, 2'(m_cred), m_err};
    endfunction

    task automatic m_advance(input int w);
        if (w >= 0 && !credit_in) m_cred = m_cred - 1;
        else if (w < 0 && credit_in) begin
            if (m_cred == DEPTH) m_err = 1;
            else m_cred = m_cred + 1;
        end
        if (w >= 0) begin
            m_sel = w;
            if (req_tail[w]) begin
                m_locked = 0;
                m_ptr    = (w + 1) % N;
            end else begin
                m_locked = 1;
                m_owner  = w;
            end
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic [4:0] td, input logic ci);
        req = r; req_tail = t; turn_disable = td; credit_in = ci;
        #1;
    endtask

    task automatic tick(input int w);
        @(posedge clk);
        m_advance(w);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; req_tail = '0; turn_disable = '0; credit_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 5'h1F; req_tail = 5'h1F; turn_disable = '0; credit_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            checks++;
            if (dut_vec !== RESET_VEC) begin
                failures++;
                $display("FAIL reset_hold k=%0d got=%h exp=%h", k, dut_vec, RESET_VEC);
            end
        end
        req = '0; req_tail = '0; credit_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_rr();
        int w; bit pf; logic [4:0] eg;
        pf = 0;
        for (int k = 0; k < 4; k++) begin
            drive(5'b00110, 5'h1F, 5'h00, pf);
            w  = m_winner();
            eg = (k % 2 == 0) ? 5'(1 << NORTH) : 5'(1 << SOUTH);
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL idle_rr k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL idle_rr_order k=%0d grant=%b exp=%b", k, grant, eg);
            end
            tick(w);
            pf = (w >= 0);
        end
    endtask

    task automatic test_packet_lock();
        int w; bit pf; int sent; logic [4:0] r, t, eg;
        pf = 1; sent = 0;
        for (int k = 0; k < 5; k++) begin
            r = (sent < 3) ? 5'b01001 : 5'b00001;
            t = 5'b00001;
            if (sent == 2) t[EAST] = 1'b1;
            drive(r, t, 5'h00, pf);
            w  = m_winner();
            eg = (k < 3) ? 5'(1 << EAST) : 5'(1 << LOCAL);
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL packet_lock k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            if (k < 4) begin
                checks++;
                if (grant !== eg) begin
                    failures++;
                    $display("FAIL packet_lock_grant k=%0d grant=%b exp=%b", k, grant, eg);
                end
            end
            tick(w);
            if (w == EAST) sent++;
            pf = (w >= 0);
        end
    endtask

    task automatic test_credit_stall();
        int w; int sent; logic [4:0] r, t; logic [9:0] fpat;
        do_reset();
        sent = 0;
        fpat = 10'b1000100011;
        for (int k = 0; k < 10; k++) begin
            r = (sent < 4) ? 5'(1 << SOUTH) : 5'b0;
            t = (sent == 3) ? 5'(1 << SOUTH) : 5'b0;
            drive(r, t, 5'h00, (k == 4) || (k == 8));
            w = m_winner();
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL credit_stall k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            checks++;
            if (fire !== fpat[k]) begin
                failures++;
                $display("FAIL credit_stall_fire k=%0d fire=%b exp=%b", k, fire, fpat[k]);
            end
            tick(w);
            if (w == SOUTH) sent++;
        end
    endtask

    task automatic test_turn_disable();
        int w; bit pf; int sent; logic [4:0] t, td;
        do_reset();
        pf = 0;
        for (int k = 0; k < 4; k++) begin
            drive(5'b10001, 5'h1F, 5'b00001, pf);
            w = m_winner();
            checks++;
            if (dut_vec !== m_vec(w) || grant !== 5'(1 << WEST)) begin
                failures++;
                $display("FAIL turn_disable k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            tick(w);
            pf = (w >= 0);
        end
        sent = 0;
        for (int k = 0; k < 4; k++) begin
            t  = 5'b00001;
            if (sent == 2) t[WEST] = 1'b1;
            td = (k == 0) ? 5'b00001 : 5'b10001;
            drive(5'b10001, t, td, pf);
            w = m_winner();
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL turn_disable_lock k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            if (k < 3) begin
                checks++;
                if (grant !== 5'(1 << WEST)) begin
                    failures++;
                    $display("FAIL turn_disable_owner k=%0d grant=%b exp=%b", k, grant, 5'(1 << WEST));
                end
            end
            tick(w);
            if (w == WEST) sent++;
            pf = (w >= 0);
        end
    endtask

    task automatic test_credit_overflow();
        int w; logic [4:0] r;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            r = (k == 0 || k == 4) ? 5'(1 << NORTH) : 5'b0;
            drive(r, 5'h1F, 5'h00, (k == 0) || (k == 1) || (k == 4));
            w = m_winner();
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL credit_overflow k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            tick(w);
        end
        checks++;
        if (credit_err !== 1'b1 || credits !== 2'd2) begin
            failures++;
            $display("FAIL credit_overflow_final err=%b credits=%0d exp err=1 credits=2", credit_err, credits);
        end
    endtask

    task automatic test_async_reset();
        int w; bit pf;
        do_reset();
        pf = 0;
        for (int k = 0; k < 2; k++) begin
            drive(5'(1 << EAST), 5'b0, 5'h00, pf);
            w = m_winner();
            tick(w);
            pf = (w >= 0);
        end
        drive(5'b11001, 5'b0, 5'h00, 1'b0);
        w = m_winner();
        checks++;
        if (dut_vec !== m_vec(w) || locked !== 1'b1) begin
            failures++;
            $display("FAIL async_pre k=0 got=%h exp=%h", dut_vec, m_vec(w));
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, RESET_VEC);
        end
        req = '0; req_tail = '0; credit_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        pf = 0;
        for (int k = 0; k < 3; k++) begin
            drive(5'h1F, 5'h1F, 5'h00, pf);
            w = m_winner();
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL async_restart k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            if (k == 0) begin
                checks++;
                if (grant !== 5'(1 << LOCAL)) begin
                    failures++;
                    $display("FAIL async_restart_first grant=%b exp=%b", grant, 5'(1 << LOCAL));
                end
            end
            tick(w);
            pf = (w >= 0);
        end
    endtask

    task automatic test_random();
        int w; logic [4:0] td;
        for (int k = 0; k < 400; k++) begin
            td = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            drive(5'($urandom), 5'($urandom), td, ($urandom_range(0, 2) == 0));
            w = m_winner();
            checks++;
            if (dut_vec !== m_vec(w)) begin
                failures++;
                $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, m_vec(w));
            end
            tick(w);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; req_tail = '0; turn_disable = '0; credit_in = 1'b0;
        m_reset();
        test_reset();
        test_idle_rr();
        test_packet_lock();
        test_credit_stall();
        test_turn_disable();
        test_credit_overflow();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port switch allocator for the NoC router; one instance per router output (NUM_PORTS instances).
- Arbitrates among input ports requesting this output and locks the output to the winner for a whole packet, through the is_tail flit.
- Gates each flit transfer on downstream credits and masks inputs whose turn to this output is disabled.
- Drives the crossbar select and the output send strobe.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports (local plus N/S/E/W).
- FLIT_BUFFER_DEPTH, 2, downstream input buffer depth; initial and maximum credit count.
- IDX_WIDTH, $clog2(NUM_INPUTS), width of the owner/select index.
- CRED_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), width of the credit counter.

Ports:
- clk  input  1  NoC clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_INPUTS  input i has a head-of-queue flit routed to this output.
- req_tail  input  NUM_INPUTS  that flit is a tail flit.
- turn_disable  input  NUM_INPUTS  input i is forbidden to turn into this output (DISABLE_TURNS column).
- credit_in  input  1  one downstream buffer slot freed this cycle.
- grant  output  NUM_INPUTS  one-hot; the flit from input i transfers this cycle (combinational).
- sel  output  IDX_WIDTH  crossbar select; equals the grant index, otherwise holds the owner/last winner.
- fire  output  1  OR of grant; drives send_out.
- fire_tail  output  1  the transferred flit is a tail.
- locked  output  1  a packet is in flight (state LOCKED).
- credits  output  CRED_WIDTH  current credit count.
- credit_err  output  1  sticky; credit_in was received while the counter was already full.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, owner=0, credits=FLIT_BUFFER_DEPTH, credit_err=0.
  - While reset is held, grant=0, fire=0, fire_tail=0, sel=0, locked=0.
- Eligibility: elig = req & ~turn_disable.
- State IDLE:
  - If credits>0 and elig≠0: the winner w is the first set bit of elig searched cyclically from rr_ptr. Assert grant[w] and fire in the same cycle (zero-cycle grant).
  - Winner with req_tail[w]=1 (single-flit packet): stay IDLE, rr_ptr←(w+1) mod NUM_INPUTS.
  - Winner with req_tail[w]=0: →LOCKED, owner←w.
  - If credits==0 or elig==0: no grant; state and rr_ptr unchanged.
- State LOCKED:
  - grant[owner] = req[owner] & (credits>0). All other inputs are ignored.
  - turn_disable is not re-evaluated mid-packet.
  - On a grant with req_tail[owner]=1: →IDLE, rr_ptr←(owner+1) mod NUM_INPUTS.
  - A bubble on the owner (req low) holds the lock indefinitely; there is no timeout.
- Credits:
  - next = credits − fire + credit_in.
  - Simultaneous fire and credit_in leaves the count unchanged, including at 0 and at FLIT_BUFFER_DEPTH.
  - fire is impossible when credits=0, so the counter never underflows.
  - credit_in with credits==FLIT_BUFFER_DEPTH and no fire: saturate at FLIT_BUFFER_DEPTH and set credit_err (cleared only by reset).
  - A credit_in arriving at credits==0 enables a grant on the next cycle, not the same cycle. Grant depends on the registered count only.
- Fairness: the pointer advances only on packet completion, so a requester waits at most NUM_INPUTS−1 packets.
- Latency: request to grant is 0 cycles when idle with credits available. State, pointer and credit updates take effect on the next clock edge.
- Reset mid-packet: the lock is dropped and credits are restored to full. Upstream and downstream are reset together via the shared noc reset synchronizer.
- Invariant: at most one grant bit is set; sel is stable while locked.

Decomposition:
- Package router_alloc_pkg:
  - alloc_state_e {IDLE, LOCKED}.
  - Function rr_pick(elig, ptr), returning one-hot plus index.
  - Localparams for the port indices LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- Sub-module rr_arbiter (NUM_INPUTS): combinational cyclic priority pick from a pointer. The pointer register lives in output_port_allocator.

Test Plan:
- Reset then idle:
  - Check: credits=2, grant=0, locked=0, credit_err=0.
  - Stimulus: req=5'b00110, all tails.
  - Required: grants are input 1, then input 2, then input 1, each a single-flit packet, with a credit_in returned per flit.
- Packet lock:
  - Stimulus: input 3 sends a 3-flit packet (tail on flit 3) while input 0 requests continuously; credit_in pulses one cycle after each fire.
  - Required: grant=5'b01000 for 3 fires, locked=1 until the tail; input 0 is granted on the next cycle.
- Credit stall:
  - Stimulus: no credit_in; input 2 sends a 4-flit packet.
  - Required: 2 fires then credits=0, fire=0, locked=1; a credit_in pulse gives credits=1 and fire resumes on the following cycle.
- Turn disable:
  - Stimulus: req=5'b10001, turn_disable=5'b00001.
  - Required: only input 4 is granted; input 0 is never granted while disabled. A turn_disable raised on the owner mid-packet does not break the lock.
- Credit overflow:
  - Stimulus: with credits=2 and fire=0, pulse credit_in.
  - Required: credits stays 2 and credit_err=1 and stays set. A simultaneous fire plus credit_in at credits=2 leaves credits=2 with credit_err unchanged.
- Async reset mid-packet:
  - Stimulus: assert rst_n=0 between edges during LOCKED.
  - Required: grant/fire drop immediately, locked=0, credits=2; after release, arbitration restarts from input 0.
